alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage_pkg.sv | 38 +++
 rtl/alu_issue_stage_decode.sv | 53 +++++
 rtl/alu_issue_stage.sv | 89 ++++++++
 tb/tb_alu_issue_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_stage_pkg.sv
// Shared ALU issue definitions: ALU operation codes and MIPS opcode/funct constants.
// Also intended for use by the ALU and the main controller.
package alu_issue_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  typedef enum logic {
    B_SEL_RT  = 1'b0,
    B_SEL_IMM = 1'b1
  } b_sel_e;

  typedef enum logic {
    EXT_SIGN = 1'b0,
    EXT_ZERO = 1'b1
  } ext_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational opcode/funct decode: ALU operation, operand-B source,
// immediate extension type and illegal-instruction flag.
module alu_op_decode
  import alu_issue_stage_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output b_sel_e     b_sel,
  output ext_e       ext,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    b_sel   = B_SEL_RT;
    ext     = EXT_SIGN;
    illegal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        alu_op = ALU_ADD;
        b_sel  = B_SEL_IMM;
      end
      OP_BEQ:  alu_op = ALU_SUB;
      OP_SLTI: begin
        alu_op = ALU_SLT;
        b_sel  = B_SEL_IMM;
      end
      OP_ANDI: begin
        alu_op = ALU_AND;
        b_sel  = B_SEL_IMM;
        ext    = EXT_ZERO;
      end
      OP_ORI: begin
        alu_op = ALU_OR;
        b_sel  = B_SEL_IMM;
        ext    = EXT_ZERO;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one instruction per cycle into registered ALU
// operands and operation, with stall/flush control and a saturating illegal counter.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_op,
  output logic              valid_out,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_cnt
);

  alu_op_e dec_op;
  b_sel_e  dec_b_sel;
  ext_e    dec_ext;
  logic    dec_illegal;

  alu_op_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_op),
    .b_sel   (dec_b_sel),
    .ext     (dec_ext),
    .illegal (dec_illegal)
  );

  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] b_next;
  logic              load;

  always_comb begin
    imm_ext = (dec_ext == EXT_ZERO) ? {{(DATA_W-16){1'b0}}, imm}
                                    : {{(DATA_W-16){imm[15]}}, imm};
    b_next  = (dec_b_sel == B_SEL_IMM) ? imm_ext : rt_data;
    load    = !flush && !stall && valid_in;
  end

  // Flush wins over stall; an idle decode slot also collapses to a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_ADD;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush || (!stall && !valid_in)) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= ALU_ADD;
      valid_out <= 1'b0;
      illegal   <= 1'b0;
    end else if (load) begin
      valid_out <= 1'b1;
      illegal   <= dec_illegal;
      if (dec_illegal) begin
        alu_a  <= '0;
        alu_b  <= '0;
        alu_op <= ALU_ADD;
      end else begin
        alu_a  <= rs_data;
        alu_b  <= b_next;
        alu_op <= dec_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (load && dec_illegal && (illegal_cnt != '1)) begin
      illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed vector table, reset and
// saturation sequences, then randomized traffic against a behavioural model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [15:0] imm;
  logic        stall;
  logic        flush;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        valid_out;
  logic        illegal;
  logic [7:0]  illegal_cnt;

  int passed = 0;
  int total  = 0;

  alu_issue_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_in    (valid_in),
    .opcode      (opcode),
    .funct       (funct),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .imm         (imm),
    .stall       (stall),
    .flush       (flush),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .valid_out   (valid_out),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v, st, fl;
    logic [5:0]  opc, fn;
    logic [31:0] rs, rt;
    logic [15:0] im;
    logic [2:0]  e_op;
    logic [31:0] e_a, e_b;
    logic        e_valid, e_ill;
    logic [7:0]  e_cnt;
  } vec_t;

  // Reference model state
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b;
  logic        m_valid, m_ill;
  int          m_cnt;

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] e_op, input logic [31:0] e_a,
                             input logic [31:0] e_b, input logic e_valid, input logic e_ill,
                             input logic [7:0] e_cnt);
    checkField({tag, ".alu_op"},      32'(alu_op),      32'(e_op));
    checkField({tag, ".alu_a"},       alu_a,            e_a);
    checkField({tag, ".alu_b"},       alu_b,            e_b);
    checkField({tag, ".valid_out"},   32'(valid_out),   32'(e_valid));
    checkField({tag, ".illegal"},     32'(illegal),     32'(e_ill));
    checkField({tag, ".illegal_cnt"}, 32'(illegal_cnt), 32'(e_cnt));
  endtask

  // Drive inputs just after a rising edge, then clock once and settle.
  task automatic applyStimulus(input logic v, input logic st, input logic fl, input logic [5:0] opc,
                               input logic [5:0] fn, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] im);
    valid_in = v; stall = st; flush = fl; opcode = opc; funct = fn;
    rs_data = rs; rt_data = rt; imm = im;
    @(posedge clk);
    #1;
  endtask

  // Instruction semantics straight from the ISA table.
  task automatic refDecode(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] im, output logic ok,
                           output logic [2:0] op, output logic [31:0] b);
    int sx;
    sx = int'($signed(im));
    ok = 1'b1; op = 3'd0; b = rt;
    case (opc)
      6'h00: case (fn)
        6'h20: op = 3'd0;
        6'h22: op = 3'd1;
        6'h24: op = 3'd2;
        6'h25: op = 3'd3;
        6'h2a: op = 3'd4;
        default: ok = 1'b0;
      endcase
      6'h08, 6'h23, 6'h2b: begin op = 3'd0; b = 32'(sx); end
      6'h04: op = 3'd1;
      6'h0a: begin op = 3'd4; b = 32'(sx); end
      6'h0c: begin op = 3'd2; b = 32'(im); end
      6'h0d: begin op = 3'd3; b = 32'(im); end
      default: ok = 1'b0;
    endcase
    if (!ok) b = 32'd0;
    if (ok) m_a = rs; else m_a = 32'd0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    valid_in = 0; stall = 0; flush = 0; opcode = 0; funct = 0;
    rs_data = 0; rt_data = 0; imm = 0;
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];

  initial begin
    logic ok;
    logic [2:0] op;
    logic [31:0] b;
    logic [5:0] opc_pool[12];

    vecs[0]  = '{1,0,0, 6'h00,6'h22, 32'd10,     32'd3,      16'h0000, 3'd1, 32'd10,     32'd3,          1,0, 8'd0};
    vecs[1]  = '{1,0,0, 6'h08,6'h00, 32'd5,      32'd77,     16'hFFFF, 3'd0, 32'd5,      32'hFFFFFFFF,   1,0, 8'd0};
    vecs[2]  = '{1,0,0, 6'h0d,6'h00, 32'd7,      32'd77,     16'hFFFF, 3'd3, 32'd7,      32'h0000FFFF,   1,0, 8'd0};
    vecs[3]  = '{1,0,0, 6'h00,6'h24, 32'hF0F0,   32'hFF00,   16'h1234, 3'd2, 32'hF0F0,   32'hFF00,       1,0, 8'd0};
    vecs[4]  = '{1,0,0, 6'h00,6'h25, 32'h1,      32'h2,      16'h0000, 3'd3, 32'h1,      32'h2,          1,0, 8'd0};
    vecs[5]  = '{1,0,0, 6'h00,6'h2a, 32'h11,     32'h22,     16'h0000, 3'd4, 32'h11,     32'h22,         1,0, 8'd0};
    vecs[6]  = '{1,0,0, 6'h23,6'h00, 32'd100,    32'd1,      16'h8000, 3'd0, 32'd100,    32'hFFFF8000,   1,0, 8'd0};
    vecs[7]  = '{1,0,0, 6'h2b,6'h00, 32'd200,    32'd1,      16'h0010, 3'd0, 32'd200,    32'h00000010,   1,0, 8'd0};
    vecs[8]  = '{1,0,0, 6'h04,6'h3f, 32'd8,      32'd9,      16'hFFFF, 3'd1, 32'd8,      32'd9,          1,0, 8'd0};
    vecs[9]  = '{1,0,0, 6'h0c,6'h00, 32'hABCD,   32'd0,      16'h8001, 3'd2, 32'hABCD,   32'h00008001,   1,0, 8'd0};
    vecs[10] = '{1,0,0, 6'h00,6'h00, 32'h55,     32'h66,     16'h7777, 3'd0, 32'd0,      32'd0,          1,1, 8'd1};
    vecs[11] = '{0,0,0, 6'h00,6'h20, 32'h55,     32'h66,     16'h0000, 3'd0, 32'd0,      32'd0,          0,0, 8'd1};
    vecs[12] = '{1,0,1, 6'h3f,6'h00, 32'h55,     32'h66,     16'h0000, 3'd0, 32'd0,      32'd0,          0,0, 8'd1};
    vecs[13] = '{1,0,0, 6'h0a,6'h00, 32'd3,      32'd4,      16'hFFFE, 3'd4, 32'd3,      32'hFFFFFFFE,   1,0, 8'd1};
    vecs[14] = '{1,1,0, 6'h00,6'h20, 32'h999,    32'h888,    16'h0001, 3'd4, 32'd3,      32'hFFFFFFFE,   1,0, 8'd1};
    vecs[15] = '{1,1,0, 6'h3f,6'h00, 32'h123,    32'h456,    16'h0002, 3'd4, 32'd3,      32'hFFFFFFFE,   1,0, 8'd1};
    vecs[16] = '{0,1,0, 6'h0d,6'h00, 32'h777,    32'h111,    16'h0003, 3'd4, 32'd3,      32'hFFFFFFFE,   1,0, 8'd1};
    vecs[17] = '{1,1,1, 6'h3f,6'h00, 32'h1,      32'h2,      16'h0004, 3'd0, 32'd0,      32'd0,          0,0, 8'd1};
    vecs[18] = '{1,1,0, 6'h3f,6'h00, 32'h1,      32'h2,      16'h0005, 3'd0, 32'd0,      32'd0,          0,0, 8'd1};

    rst_n = 1'b0;
    valid_in = 0; stall = 0; flush = 0; opcode = 0; funct = 0;
    rs_data = 0; rt_data = 0; imm = 0;
    #3;
    checkOutput("reset", 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].v, vecs[i].st, vecs[i].fl, vecs[i].opc, vecs[i].fn,
                    vecs[i].rs, vecs[i].rt, vecs[i].im);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_op, vecs[i].e_a, vecs[i].e_b,
                  vecs[i].e_valid, vecs[i].e_ill, vecs[i].e_cnt);
    end

    // Asynchronous reset between edges while a real instruction is held.
    applyStimulus(1, 0, 0, 6'h00, 6'h20, 32'hDEAD, 32'hBEEF, 16'h0);
    checkOutput("pre_async", 3'd0, 32'hDEAD, 32'hBEEF, 1'b1, 1'b0, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    stall = 1; flush = 1;
    @(posedge clk);
    #1;
    checkOutput("reset_holds", 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    applyStimulus(1, 0, 0, 6'h0a, 6'h00, 32'd42, 32'd0, 16'h0005);
    checkOutput("post_reset", 3'd4, 32'd42, 32'd5, 1'b1, 1'b0, 8'd0);

    // Counter saturation with 300 consecutive illegal opcodes.
    doReset();
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1, 0, 0, 6'h3f, 6'h00, 32'(i), 32'(i), 16'(i));
      checkField("sat.illegal", 32'(illegal), 32'd1);
      checkField("sat.cnt", 32'(illegal_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    applyStimulus(1, 0, 1, 6'h3f, 6'h00, 32'd1, 32'd1, 16'd1);
    checkOutput("sat_flush", 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 8'd255);

    // Randomized traffic against the behavioural model.
    opc_pool = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h0a, 6'h0c, 6'h0d, 6'h3f, 6'h02};
    doReset();
    m_op = 0; m_a = 0; m_b = 0; m_valid = 0; m_ill = 0; m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic v, st, fl;
      logic [5:0] opc, fn;
      logic [31:0] rs, rt, a_save;
      logic [15:0] im;
      v   = ($urandom_range(7) != 0);
      st  = ($urandom_range(3) == 0);
      fl  = ($urandom_range(7) == 0);
      opc = ($urandom_range(9) == 0) ? 6'($urandom) : opc_pool[$urandom_range(11)];
      case ($urandom_range(5))
        0: fn = 6'h20; 1: fn = 6'h22; 2: fn = 6'h24; 3: fn = 6'h25; 4: fn = 6'h2a;
        default: fn = 6'($urandom);
      endcase
      rs = $urandom; rt = $urandom; im = 16'($urandom);
      if (fl || (!st && !v)) begin
        m_op = 0; m_a = 0; m_b = 0; m_valid = 0; m_ill = 0;
      end else if (!st) begin
        a_save = m_a;
        refDecode(opc, fn, rs, rt, im, ok, op, b);
        m_op = op; m_b = b; m_valid = 1; m_ill = !ok;
        if (!ok && m_cnt < 255) m_cnt++;
      end
      applyStimulus(v, st, fl, opc, fn, rs, rt, im);
      checkOutput($sformatf("rand%0d", i), m_op, m_a, m_b, m_valid, m_ill, 8'(m_cnt));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: got running expected finished");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "[TB] timeout");
  end

endmodule
